operand2_decode: RTL and testbench

- Data-processing operand-2 stage sitting directly upstream of the barrel shifter.
- Takes the instruction's 12-bit shifter-operand field, I bit, Rm and Rs read data, and the current C flag.
- Produces the registered operand, opcode, shift amount and carry that drive the shifter's inputs, behind a valid/ready handshake.
- Resolves every ARM operand-2 encoding, including immediate rotates, RRX and register-specified amounts of 0 or 32 and above, into forms the 5-bit shifter computes correctly.

---
 rtl/operand2_decode.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_operand2_decode.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand2_decode.sv
// ---------------------------------------------------------------------------
// operand2_decode
//
// Data-processing operand-2 stage placed directly in front of the barrel
// shifter. It turns the 12-bit shifter-operand field into shifter inputs
// (operand, opcode, 5-bit amount, carry-in) that the shifter can compute
// without special cases:
//   - immediate rotates become ROR by an even amount,
//   - LSR #32 / ASR #32 / RRX immediate encodings are rewritten,
//   - register-specified amounts of 0 and of 32 or more are folded into a
//     pre-computed operand with LSL #0.
// The result is registered behind a valid/ready handshake.
//
// Parameters
//   REG_SHIFT_EXTRA_CYCLE  1: register-specified shifts go through RS_WAIT
//                             (2-cycle latency); 0: every form takes 1 cycle
//
// Ports
//   clk        in   1   clock, rising edge
//   reset      in   1   asynchronous active-high reset
//   in_valid   in   1   upstream presents an operand
//   in_ready   out  1   stage accepts this cycle
//   i_bit      in   1   instruction bit 25 (immediate operand)
//   op2_field  in  12   instruction bits [11:0]
//   rm_data    in  32   Rm register value
//   rs_data    in  32   Rs register value (only [7:0] used)
//   carry_in   in   1   current CPSR C flag
//   out_valid  out  1   shifter inputs valid
//   out_ready  in   1   downstream consumes this cycle
//   sh_a       out 32   shifter operand
//   sh_opcode  out  3   LSL=0, LSR=1, ASR=2, ROR=3, RRX=4
//   sh_shift   out  5   shifter amount
//   sh_carry   out  1   shifter carry-in
// ---------------------------------------------------------------------------
module operand2_decode #(
  parameter bit REG_SHIFT_EXTRA_CYCLE = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        i_bit,
  input  logic [11:0] op2_field,
  input  logic [31:0] rm_data,
  input  logic [31:0] rs_data,
  input  logic        carry_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] sh_a,
  output logic [2:0]  sh_opcode,
  output logic [4:0]  sh_shift,
  output logic        sh_carry
);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_FULL    = 2'd1,
    ST_RS_WAIT = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    OP_LSL = 3'd0,
    OP_LSR = 3'd1,
    OP_ASR = 3'd2,
    OP_ROR = 3'd3,
    OP_RRX = 3'd4
  } sh_op_e;

  typedef enum logic [1:0] {
    TY_LSL = 2'd0,
    TY_LSR = 2'd1,
    TY_ASR = 2'd2,
    TY_ROR = 2'd3
  } sh_type_e;

  typedef struct packed {
    logic [31:0] a;
    logic [2:0]  opcode;
    logic [4:0]  shift;
    logic        carry;
  } sh_out_t;

  // -------------------------------------------------------------------------
  // Operand-2 decode. amt is the register-specified amount (Rs[7:0]); it is
  // ignored for immediate and immediate-shift forms.
  // -------------------------------------------------------------------------
  function automatic sh_out_t decode(
    input logic        ib,
    input logic [11:0] op2,
    input logic [31:0] rm,
    input logic [7:0]  amt,
    input logic        c
  );
    sh_out_t  r;
    sh_type_e typ;
    logic [4:0] imm;
    logic       amt_ge32;

    typ      = sh_type_e'(op2[6:5]);
    imm      = op2[11:7];
    amt_ge32 = |amt[7:5];

    // Default is a plain pass-through of Rm (LSL #0).
    r.a      = rm;
    r.opcode = OP_LSL;
    r.shift  = 5'd0;
    r.carry  = c;

    if (ib) begin
      // 8-bit immediate rotated right by twice the 4-bit rotate field.
      r.a      = {24'h0, op2[7:0]};
      r.opcode = OP_ROR;
      r.shift  = {op2[11:8], 1'b0};
    end else if (!op2[4]) begin
      case (typ)
        TY_LSL: begin
          r.opcode = OP_LSL;
          r.shift  = imm;
        end
        TY_LSR: begin
          // imm=0 means LSR #32; the shifter returns 0 for LSR by 0.
          r.opcode = OP_LSR;
          r.shift  = imm;
        end
        TY_ASR: begin
          if (imm == 5'd0) begin
            // ASR #32: every bit becomes the sign bit.
            r.a = {32{rm[31]}};
          end else begin
            r.opcode = OP_ASR;
            r.shift  = imm;
          end
        end
        default: begin
          if (imm == 5'd0) begin
            r.opcode = OP_RRX;
          end else begin
            r.opcode = OP_ROR;
            r.shift  = imm;
          end
        end
      endcase
    end else if (amt != 8'd0) begin
      // Register-specified amount; bit 7 of the field is deliberately ignored.
      case (typ)
        TY_LSL: begin
          if (amt_ge32) begin
            r.a = 32'h0;
          end else begin
            r.opcode = OP_LSL;
            r.shift  = amt[4:0];
          end
        end
        TY_LSR: begin
          if (amt_ge32) begin
            r.a = 32'h0;
          end else begin
            r.opcode = OP_LSR;
            r.shift  = amt[4:0];
          end
        end
        TY_ASR: begin
          if (amt_ge32) begin
            r.a = {32{rm[31]}};
          end else begin
            r.opcode = OP_ASR;
            r.shift  = amt[4:0];
          end
        end
        default: begin
          // A rotate by a multiple of 32 leaves the operand unchanged.
          if (amt[4:0] != 5'd0) begin
            r.opcode = OP_ROR;
            r.shift  = amt[4:0];
          end
        end
      endcase
    end
    return r;
  endfunction

  // -------------------------------------------------------------------------
  // Handshake and control
  // -------------------------------------------------------------------------
  state_e state_q, state_d;

  logic accept;
  logic is_reg_shift;
  logic go_wait;
  logic load_out;

  assign accept       = in_valid && in_ready;
  assign is_reg_shift = !i_bit && op2_field[4];
  assign go_wait      = accept && is_reg_shift && REG_SHIFT_EXTRA_CYCLE;
  assign load_out     = (accept && !go_wait) || (state_q == ST_RS_WAIT);

  // State register.
  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values, regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) state_d = go_wait ? ST_RS_WAIT : ST_FULL;
      end
      ST_FULL: begin
        if (accept)         state_d = go_wait ? ST_RS_WAIT : ST_FULL;
        else if (out_ready) state_d = ST_EMPTY;
      end
      ST_RS_WAIT: begin
        state_d = ST_FULL;
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  // Handshake outputs.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        in_ready = 1'b1;
      end
      ST_FULL: begin
        in_ready  = out_ready;
        out_valid = 1'b1;
      end
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Capture for the register-shift extra cycle
  // -------------------------------------------------------------------------
  logic [11:0] op2_q;
  logic [31:0] rm_q;
  logic [7:0]  rs_q;
  logic        carry_q;

  // NOTE: these holding registers have no reset; they are only read in
  // RS_WAIT, which is always entered by loading them first.
  always_ff @(posedge clk) begin
    if (go_wait) begin
      op2_q   <= op2_field;
      rm_q    <= rm_data;
      rs_q    <= rs_data[7:0];
      carry_q <= carry_in;
    end
  end

  // -------------------------------------------------------------------------
  // Output registers
  // -------------------------------------------------------------------------
  sh_out_t out_q, out_d;

  always_comb begin
    if (state_q == ST_RS_WAIT) begin
      out_d = decode(1'b0, op2_q, rm_q, rs_q, carry_q);
    end else begin
      out_d = decode(i_bit, op2_field, rm_data, rs_data[7:0], carry_in);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q <= '0;
    end else if (load_out) begin
      out_q <= out_d;
    end
  end

  assign sh_a      = out_q.a;
  assign sh_opcode = out_q.opcode;
  assign sh_shift  = out_q.shift;
  assign sh_carry  = out_q.carry;

  // Rs bits above the 8-bit amount never influence the result.
  logic unused_rs_hi;
  assign unused_rs_hi = ^rs_data[31:8];

endmodule

// File: tb/tb_operand2_decode.sv
// ---------------------------------------------------------------------------
// tb_operand2_decode
//
// Self-checking bench for operand2_decode (REG_SHIFT_EXTRA_CYCLE=1).
// Directed scenarios cover reset, immediate forms, the zero-amount immediate
// shift encodings, register-shift latency, backpressure and streaming; a
// randomized phase then compares every drained output against a behavioural
// model through an in-order scoreboard.
// ---------------------------------------------------------------------------
module tb_operand2_decode;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        i_bit;
  logic [11:0] op2_field;
  logic [31:0] rm_data;
  logic [31:0] rs_data;
  logic        carry_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sh_a;
  logic [2:0]  sh_opcode;
  logic [4:0]  sh_shift;
  logic        sh_carry;

  operand2_decode #(.REG_SHIFT_EXTRA_CYCLE(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .i_bit     (i_bit),
    .op2_field (op2_field),
    .rm_data   (rm_data),
    .rs_data   (rs_data),
    .carry_in  (carry_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sh_a      (sh_a),
    .sh_opcode (sh_opcode),
    .sh_shift  (sh_shift),
    .sh_carry  (sh_carry)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ib;
    logic [11:0] op2;
    logic [31:0] rm;
    logic [31:0] rs;
    logic        c;
  } op_t;

  typedef struct {
    logic [31:0] a;
    logic [2:0]  opc;
    logic [4:0]  sh;
    logic        c;
  } exp_t;

  int   tests = 0;
  int   fails = 0;
  int   drained = 0;
  exp_t sb_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Behavioural model: the ARM operand-2 meaning of the encoding, reduced to
  // what a 5-bit shifter needs.
  function automatic exp_t model(input op_t o);
    exp_t        e;
    int          amt;
    int          typ;
    logic [31:0] sign;
    e.a   = o.rm;
    e.opc = 3'd0;
    e.sh  = 5'd0;
    e.c   = o.c;
    sign  = o.rm[31] ? 32'hFFFF_FFFF : 32'h0;
    if (o.ib) begin
      e.a   = {24'h0, o.op2[7:0]};
      e.opc = 3'd3;
      e.sh  = 5'(2 * int'(o.op2[11:8]));
      return e;
    end
    typ = int'(o.op2[6:5]);
    if (!o.op2[4]) begin
      amt = int'(o.op2[11:7]);
      if (amt == 0) begin
        case (typ)
          1:       e.opc = 3'd1;   // LSR #32, shifter gives 0 for amount 0
          2:       e.a   = sign;   // ASR #32
          3:       e.opc = 3'd4;   // RRX
          default: ;               // LSL #0
        endcase
        return e;
      end
    end else begin
      amt = int'(o.rs[7:0]);
    end
    if (amt == 0) return e;
    case (typ)
      0: if (amt < 32) begin e.opc = 3'd0; e.sh = 5'(amt); end else e.a = 32'h0;
      1: if (amt < 32) begin e.opc = 3'd1; e.sh = 5'(amt); end else e.a = 32'h0;
      2: if (amt < 32) begin e.opc = 3'd2; e.sh = 5'(amt); end else e.a = sign;
      default: if ((amt % 32) != 0) begin e.opc = 3'd3; e.sh = 5'(amt % 32); end
    endcase
    return e;
  endfunction

  function automatic op_t mk(input logic ib, input logic [11:0] op2, input logic [31:0] rm,
                             input logic [31:0] rs, input logic c);
    op_t o;
    o.ib = ib; o.op2 = op2; o.rm = rm; o.rs = rs; o.c = c;
    return o;
  endfunction

  function automatic op_t rand_op(input bit allow_reg);
    op_t o;
    o.ib  = ($urandom_range(0, 3) == 0);
    o.op2 = 12'($urandom);
    if (!allow_reg) o.op2[4] = 1'b0;
    if ($urandom_range(0, 3) == 0) o.op2[11:7] = 5'd0;
    o.rm  = ($urandom_range(0, 3) == 0) ? 32'h8000_0001 : $urandom;
    case ($urandom_range(0, 5))
      0:       o.rs = 32'h0;
      1:       o.rs = $urandom_range(1, 31);
      2:       o.rs = 32'd32;
      3:       o.rs = $urandom_range(33, 255);
      4:       o.rs = $urandom;
      default: o.rs = 32'h20 * $urandom_range(1, 7);
    endcase
    o.c = 1'($urandom);
    return o;
  endfunction

  // One clock cycle: drive at the falling edge, let combinational outputs
  // settle, score the handshakes that the next rising edge will perform.
  task automatic cycle(input logic v, input op_t o, input logic ordy);
    exp_t e;
    @(negedge clk);
    in_valid  = v;
    i_bit     = o.ib;
    op2_field = o.op2;
    rm_data   = o.rm;
    rs_data   = o.rs;
    carry_in  = o.c;
    out_ready = ordy;
    #1;
    if (out_valid && out_ready) begin
      drained++;
      if (sb_q.size() == 0) begin
        check("unexpected_output", 32'(out_valid), 32'h0);
      end else begin
        e = sb_q.pop_front();
        check("sb_a",     sh_a,               e.a);
        check("sb_opcode", 32'(sh_opcode),    32'(e.opc));
        check("sb_shift",  32'(sh_shift),     32'(e.sh));
        check("sb_carry",  32'(sh_carry),     32'(e.c));
      end
    end
    if (in_valid && in_ready) sb_q.push_back(model(o));
  endtask

  task automatic expect_out(input string tag, input logic [31:0] a, input logic [2:0] opc,
                            input logic [4:0] sh, input logic c);
    check({tag, "_valid"},  32'(out_valid), 32'h1);
    check({tag, "_a"},      sh_a,           a);
    check({tag, "_opcode"}, 32'(sh_opcode), 32'(opc));
    check({tag, "_shift"},  32'(sh_shift),  32'(sh));
    check({tag, "_carry"},  32'(sh_carry),  32'(c));
  endtask

  op_t idle;
  op_t o;

  initial begin
    idle      = mk(1'b0, 12'h0, 32'h0, 32'h0, 1'b0);
    reset     = 1'b1;
    in_valid  = 1'b0;
    i_bit     = 1'b0;
    op2_field = 12'h0;
    rm_data   = 32'h0;
    rs_data   = 32'h0;
    carry_in  = 1'b0;
    out_ready = 1'b0;

    // Reset state.
    #3;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_in_ready",  32'(in_ready),  32'h1);
    check("rst_sh_a",      sh_a,           32'h0);
    check("rst_sh_opcode", 32'(sh_opcode), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Immediate: 0xFF rotated by 8.
    cycle(1'b1, mk(1'b1, 12'h4FF, 32'hDEAD_BEEF, 32'h0, 1'b1), 1'b1);
    cycle(1'b0, idle, 1'b0);
    expect_out("imm", 32'h0000_00FF, 3'd3, 5'd8, 1'b1);
    cycle(1'b0, idle, 1'b1);

    // Zero-amount immediate shifts, rm = 0x80000001.
    cycle(1'b1, mk(1'b0, 12'h020, 32'h8000_0001, 32'h0, 1'b0), 1'b1);
    cycle(1'b0, idle, 1'b0);
    expect_out("lsr0", 32'h8000_0001, 3'd1, 5'd0, 1'b0);
    cycle(1'b0, idle, 1'b1);

    cycle(1'b1, mk(1'b0, 12'h060, 32'h8000_0001, 32'h0, 1'b1), 1'b1);
    cycle(1'b0, idle, 1'b0);
    expect_out("ror0", 32'h8000_0001, 3'd4, 5'd0, 1'b1);
    cycle(1'b0, idle, 1'b1);

    cycle(1'b1, mk(1'b0, 12'h040, 32'h8000_0001, 32'h0, 1'b0), 1'b1);
    cycle(1'b0, idle, 1'b0);
    expect_out("asr0", 32'hFFFF_FFFF, 3'd0, 5'd0, 1'b0);
    cycle(1'b0, idle, 1'b1);

    // Register LSL by 40: one RS_WAIT cycle, then shifted-out operand.
    cycle(1'b1, mk(1'b0, 12'h010, 32'h1234_5678, 32'h28, 1'b0), 1'b1);
    cycle(1'b0, idle, 1'b1);
    check("rsw_in_ready",  32'(in_ready),  32'h0);
    check("rsw_out_valid", 32'(out_valid), 32'h0);
    cycle(1'b0, idle, 1'b0);
    expect_out("lsl40", 32'h0, 3'd0, 5'd0, 1'b0);
    cycle(1'b0, idle, 1'b1);

    // Register ROR by 0x24 -> ROR #4.
    cycle(1'b1, mk(1'b0, 12'h070, 32'h1234_5678, 32'h24, 1'b1), 1'b1);
    cycle(1'b0, idle, 1'b1);
    cycle(1'b0, idle, 1'b0);
    expect_out("ror36", 32'h1234_5678, 3'd3, 5'd4, 1'b1);
    cycle(1'b0, idle, 1'b1);

    // Backpressure: outputs hold while out_ready=0, then drain+load together.
    cycle(1'b1, mk(1'b1, 12'h3A5, 32'h0, 32'h0, 1'b1), 1'b1);
    o = mk(1'b0, 12'h0A0, 32'hCAFE_F00D, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, o, 1'b0);
      check("bp_in_ready", 32'(in_ready), 32'h0);
      expect_out("bp_hold", 32'h0000_00A5, 3'd3, 5'd6, 1'b1);
    end
    cycle(1'b1, o, 1'b1);
    cycle(1'b0, idle, 1'b0);
    expect_out("bp_new", 32'hCAFE_F00D, 3'd1, 5'd1, 1'b0);
    cycle(1'b0, idle, 1'b1);

    // Streaming: back-to-back non-register operands, no bubbles.
    drained = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, rand_op(1'b0), 1'b1);
      check("stream_in_ready", 32'(in_ready), 32'h1);
      if (i > 0) check("stream_out_valid", 32'(out_valid), 32'h1);
    end
    cycle(1'b0, idle, 1'b1);
    check("stream_count", 32'(drained), 32'd20);

    // Asynchronous reset mid-stream.
    cycle(1'b1, mk(1'b1, 12'hFFF, 32'h0, 32'h0, 1'b1), 1'b0);
    cycle(1'b0, idle, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("mrst_out_valid", 32'(out_valid), 32'h0);
    check("mrst_in_ready",  32'(in_ready),  32'h1);
    check("mrst_sh_a",      sh_a,           32'h0);
    check("mrst_sh_opcode", 32'(sh_opcode), 32'h0);
    check("mrst_sh_shift",  32'(sh_shift),  32'h0);
    check("mrst_sh_carry",  32'(sh_carry),  32'h0);
    sb_q.delete();
    @(negedge clk);
    reset = 1'b0;

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), rand_op(1'b1), 1'($urandom_range(0, 3) != 0));
    end

    // Bounded drain of anything still in flight.
    for (int i = 0; i < 10; i++) begin
      if (sb_q.size() != 0) cycle(1'b0, idle, 1'b1);
    end
    check("final_sb_empty", 32'(sb_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
